// File: rtl/core_pipe_pkg.sv
// Shared pipeline-stage types: slot state encoding, default NOP and the IF->ID payload.
package core_pipe_pkg;

    localparam int unsigned IF_ID_XLEN = 32;
    localparam logic [IF_ID_XLEN-1:0] NOP_INSTR_DEF = 32'h00000013;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        SKID
    } pipe_state_t;

    typedef struct packed {
        logic [IF_ID_XLEN-1:0] pc;
        logic [IF_ID_XLEN-1:0] pc_plus4;
        logic [IF_ID_XLEN-1:0] instr;
    } if_id_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register: valid/ready on both sides, 2-entry skid, flush-to-bubble,
// and a saturating bubble counter for performance debug.
module if_id_pipe_reg
    import core_pipe_pkg::*;
#(
    // Payload struct is sized by the package; XLEN must stay equal to IF_ID_XLEN.
    parameter int unsigned     XLEN      = IF_ID_XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic [XLEN-1:0]  in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_pc_plus4,
    output logic [XLEN-1:0]  out_instr,
    output logic [CNT_W-1:0] bubble_cnt
);

    pipe_state_t    state_q, state_d;
    if_id_payload_t main_q, main_d;
    if_id_payload_t skid_q, skid_d;
    if_id_payload_t in_payload;
    logic           in_fire;
    logic           out_fire;

    assign in_payload = '{pc: in_pc, pc_plus4: in_pc_plus4, instr: in_instr};

    // Both handshakes decode from registered state only, so no comb path crosses the stage.
    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        main_d  = in_payload;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_payload;
                    end else if (in_fire) begin
                        state_d = SKID;
                        skid_d  = in_payload;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '{pc: '0, pc_plus4: '0, instr: NOP_INSTR};
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_pc       = main_q.pc;
    assign out_pc_plus4 = main_q.pc_plus4;
    assign out_instr    = out_valid ? main_q.instr : NOP_INSTR;

    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk    (clk),
        .inc_i  (~out_valid & out_ready),
        .clr_i  (rst),
        .count_o(bubble_cnt)
    );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg, checked every cycle against a 2-deep FIFO model.
module tb_if_id_pipe_reg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc = '0;
    logic [XLEN-1:0]  in_pc_plus4 = '0;
    logic [XLEN-1:0]  in_instr = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_pc_plus4;
    logic [XLEN-1:0]  out_instr;
    logic [CNT_W-1:0] bubble_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    if_id_pipe_reg #(
        .XLEN     (XLEN),
        .NOP_INSTR(NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_pc_plus4 (in_pc_plus4),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_pc_plus4(out_pc_plus4),
        .out_instr   (out_instr),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the register is a FIFO of capacity 2 whose head is what decode sees.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    entry_t m_q[$];
    int     m_cnt = 0;
    bit     started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_cnt = 0;
        end else begin
            if (m_q.size() == 0 && out_ready && m_cnt < 15) m_cnt++;
            if (flush) begin
                m_q.delete();
            end else begin
                bit can_take;
                can_take = (m_q.size() < 2);
                if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
                if (in_valid && can_take) m_q.push_back('{in_pc, in_pc_plus4, in_instr});
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
            chk("model_in_ready", {31'b0, in_ready}, {31'b0, m_q.size() < 2});
            chk("model_bubble_cnt", {28'b0, bubble_cnt}, m_cnt);
            if (m_q.size() > 0) begin
                chk("model_out_pc", out_pc, m_q[0].pc);
                chk("model_out_pc_plus4", out_pc_plus4, m_q[0].pc4);
                chk("model_out_instr", out_instr, m_q[0].instr);
            end else begin
                chk("model_out_instr_nop", out_instr, NOP);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid    = v;
        in_pc       = pc;
        in_pc_plus4 = pc + 32'd4;
        in_instr    = ins;
    endtask

    initial begin
        // Reset for two edges.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h00000013);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_pc_plus4", out_pc_plus4, 32'd0);
        chk("rst_bubble_cnt", {28'b0, bubble_cnt}, 32'd0);
        tick();
        chk("rst_in_ready_after", {31'b0, in_ready}, 32'd1);
        chk("rst_bubble_hold", {28'b0, bubble_cnt}, 32'd0);

        // Streaming, one cycle latency, no gaps.
        out_ready = 1'b1;
        drive(1'b1, 32'h0, 32'h00500093);
        tick();
        chk("stream0_pc", out_pc, 32'h0);
        chk("stream0_instr", out_instr, 32'h00500093);
        drive(1'b1, 32'h4, 32'h00600113);
        tick();
        chk("stream1_pc", out_pc, 32'h4);
        chk("stream1_instr", out_instr, 32'h00600113);
        drive(1'b1, 32'h8, 32'h002081B3);
        tick();
        chk("stream2_pc", out_pc, 32'h8);
        chk("stream2_pc4", out_pc_plus4, 32'hC);
        chk("stream2_valid", {31'b0, out_valid}, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("stream_drain_valid", {31'b0, out_valid}, 32'd0);

        // Back-pressure into the skid slot.
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 32'h11111111);
        tick();
        chk("bp_first_pc", out_pc, 32'h10);
        drive(1'b1, 32'h14, 32'h22222222);
        tick();
        chk("bp_skid_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_skid_pc_held", out_pc, 32'h10);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("bp_hold_pc", out_pc, 32'h10);
        chk("bp_hold_instr", out_instr, 32'h11111111);
        out_ready = 1'b1;
        tick();
        chk("bp_release_pc", out_pc, 32'h14);
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("bp_empty_valid", {31'b0, out_valid}, 32'd0);

        // Flush while in SKID with an incoming word presented.
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 32'h33333333);
        tick();
        drive(1'b1, 32'h24, 32'h44444444);
        tick();
        chk("fl_skid_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h28, 32'h55555555);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_out_instr", out_instr, 32'h00000013);
        out_ready = 1'b1;
        tick();
        chk("fl_stays_empty", {31'b0, out_valid}, 32'd0);
        tick();
        chk("fl_stays_empty2", {31'b0, out_valid}, 32'd0);

        // Reset and flush together while FULL.
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 32'h66666666);
        tick();
        chk("rf_full_pc", out_pc, 32'h30);
        drive(1'b0, 32'h0, 32'h0);
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        chk("rf_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rf_out_pc", out_pc, 32'd0);
        chk("rf_out_instr", out_instr, 32'h00000013);
        chk("rf_bubble_cnt", {28'b0, bubble_cnt}, 32'd0);

        // Bubble counter saturation with CNT_W=4.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_cnt_14", {28'b0, bubble_cnt}, 32'd14);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_cnt_hold", {28'b0, bubble_cnt}, 32'hF);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
